// File: rtl/fp_pkg.sv
// fp_pkg: shared IEEE-754 field geometry, operand classes and exception flags
package fp_pkg;
  typedef enum logic [2:0] {ZERO, NORMAL, INF, QNAN, SNAN} fp_class_e;
  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;
  function automatic int exp_w(input int n);
    return n == 64 ? 11 : 8;
  endfunction
  function automatic int man_w(input int n);
    return n == 64 ? 52 : 23;
  endfunction
  function automatic int bias(input int n);
    return (1 << (exp_w(n) - 1)) - 1;
  endfunction
  // canonical quiet NaN: exponent all ones plus fraction MSB, sign 0
  function automatic logic [63:0] qnan(input int n);
    logic [63:0] q;
    q = '0;
    for (int i = man_w(n) - 1; i < n - 1; i++) q[i] = 1'b1;
    return q;
  endfunction
endpackage

// File: rtl/fmul_pipe_if.sv
// fmul_pipe_if: operand/result valid-ready channels of the FP multiplier
interface fmul_pipe_if
  import fp_pkg::*;
#(
  parameter int N = 32
);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0] a, b, out;
  fp_flags_t flags;
  modport master(output in_valid, a, b, out_ready, input in_ready, out_valid, out, flags);
  modport slave(input in_valid, a, b, out_ready, output in_ready, out_valid, out, flags);
endinterface

// File: rtl/fp_round_pack.sv
// fp_round_pack: normalise, round-to-nearest-even, saturate and pack a raw significand product
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                     sign,
  input  logic [exp_w(N)+1:0]      expo,
  input  logic [2*man_w(N)+1:0]    prod,
  input  logic                     byp,
  input  logic [N-1:0]             byp_res,
  input  logic                     byp_inv,
  output logic [N-1:0]             res,
  output fp_flags_t                flags
);
  localparam int EXP_W = exp_w(N);
  localparam int MAN_W = man_w(N);
  localparam logic [EXP_W+1:0] EMAX = (EXP_W + 2)'((1 << EXP_W) - 1);
  logic [2*MAN_W:0] norm;
  logic [MAN_W:0] mr;
  logic [EXP_W+1:0] en, er;
  logic guard, sticky, up, uf, of;
  // exponents are two's complement in EXP_W+2 bits; the top bit is the sign
  always_comb begin
    norm = prod[2*MAN_W+1] ? prod[2*MAN_W:0] : {prod[2*MAN_W-1:0], 1'b0};
    en = expo + {{(EXP_W + 1){1'b0}}, prod[2*MAN_W+1]};
    guard = norm[MAN_W];
    sticky = |norm[MAN_W-1:0];
    up = guard && (sticky || norm[MAN_W+1]);
    mr = {1'b0, norm[2*MAN_W:MAN_W+1]} + {{MAN_W{1'b0}}, up};
    er = en + {{(EXP_W + 1){1'b0}}, mr[MAN_W]};
    uf = en[EXP_W+1] || en == '0;
    of = !er[EXP_W+1] && er >= EMAX;
    res = byp ? byp_res
        : uf ? {sign, {(N - 1){1'b0}}}
        : of ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
        : {sign, er[EXP_W-1:0], mr[MAN_W-1:0]};
    flags = byp ? {byp_inv, 3'b000} : {1'b0, of && !uf, uf, uf || of || guard || sticky};
  end
endmodule

// File: rtl/fmul_pipe.sv
// fmul_pipe: 3-stage IEEE-754 binary32/64 multiplier (DAZ/FTZ, RNE) with valid/ready flow control
module fmul_pipe
  import fp_pkg::*;
#(
  parameter int N = 32
) (
  input logic        clk,
  input logic        rst,
  fmul_pipe_if.slave io
);
  localparam int EXP_W = exp_w(N);
  localparam int MAN_W = man_w(N);
  localparam int PW = 2 * MAN_W + 2;
  localparam logic [EXP_W+1:0] BIAS = (EXP_W + 2)'(bias(N));
  localparam logic [N-1:0] QNAN_BITS = N'(qnan(N));
  if (N != 32 && N != 64) begin : g_bad_n
    $error("fmul_pipe: N must be 32 or 64");
  end
  logic [EXP_W-1:0] ea, eb;
  fp_class_e ca, cb;
  logic sgn, nan, inf, zero, byp_d, inv_d, advance;
  logic [N-1:0] res_d, res3;
  fp_flags_t fl3;
  logic v1, v2, s1, s2, b1, b2, i1, i2;
  logic [EXP_W+1:0] e1, e2;
  logic [MAN_W:0] ma1, mb1;
  logic [PW-1:0] p2;
  logic [N-1:0] r1, r2;
  assign ea = io.a[N-2:MAN_W];
  assign eb = io.b[N-2:MAN_W];
  // subnormal inputs classify as zero
  assign ca = ea == '0 ? ZERO : ea != '1 ? NORMAL : io.a[MAN_W-1:0] == '0 ? INF : io.a[MAN_W-1] ? QNAN : SNAN;
  assign cb = eb == '0 ? ZERO : eb != '1 ? NORMAL : io.b[MAN_W-1:0] == '0 ? INF : io.b[MAN_W-1] ? QNAN : SNAN;
  assign sgn = io.a[N-1] ^ io.b[N-1];
  assign nan = ca inside {QNAN, SNAN} || cb inside {QNAN, SNAN};
  assign inf = ca == INF || cb == INF;
  assign zero = ca == ZERO || cb == ZERO;
  assign byp_d = nan || inf || zero;
  assign inv_d = ca == SNAN || cb == SNAN || (inf && zero);
  assign res_d = (nan || (inf && zero)) ? QNAN_BITS
               : inf ? {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
               : {sgn, {(N - 1){1'b0}}};
  assign advance = !io.out_valid || io.out_ready;
  assign io.in_ready = advance;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      io.out_valid <= 1'b0;
      io.out <= '0;
      io.flags <= '0;
    end else if (advance) begin
      v1 <= io.in_valid;
      v2 <= v1;
      io.out_valid <= v2;
      io.out <= res3;
      io.flags <= fl3;
    end
  // datapath registers carry no reset; the valid bits qualify them
  always_ff @(posedge clk)
    if (advance) begin
      s1 <= sgn;
      e1 <= {2'b00, ea} + {2'b00, eb} - BIAS;
      ma1 <= {1'b1, io.a[MAN_W-1:0]};
      mb1 <= {1'b1, io.b[MAN_W-1:0]};
      b1 <= byp_d;
      i1 <= inv_d;
      r1 <= res_d;
      s2 <= s1;
      e2 <= e1;
      p2 <= ma1 * mb1;
      b2 <= b1;
      i2 <= i1;
      r2 <= r1;
    end
  fp_round_pack #(.N(N)) u_round_pack (
    .sign(s2), .expo(e2), .prod(p2), .byp(b2), .byp_res(r2), .byp_inv(i2), .res(res3), .flags(fl3)
  );
endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: directed and randomized checks of fmul_pipe against an integer-arithmetic reference
module tb_fmul_pipe;
  logic clk, rst;
  int n_chk, n_pass, n_out;
  logic [67:0] exp_q[$];
  bit rnd_done;
  fmul_pipe_if #(.N(32)) i32 ();
  fmul_pipe_if #(.N(64)) i64 ();
  fmul_pipe #(.N(32)) u32 (.clk(clk), .rst(rst), .io(i32.slave));
  fmul_pipe #(.N(64)) u64 (.clk(clk), .rst(rst), .io(i64.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  localparam logic [99:0] DIR [10] = '{
    {32'h3FC00000, 32'h40000000, 4'h0, 32'h40400000},
    {32'hC0000000, 32'h3F000000, 4'h0, 32'hBF800000},
    {32'h3F800001, 32'h3FC00000, 4'h1, 32'h3FC00002},
    {32'h3F800001, 32'h3F800001, 4'h1, 32'h3F800002},
    {32'h7F800000, 32'h00000000, 4'h8, 32'h7FC00000},
    {32'hFF800000, 32'h40000000, 4'h0, 32'hFF800000},
    {32'h7FC00000, 32'h3F800000, 4'h0, 32'h7FC00000},
    {32'h7F000000, 32'h7F000000, 4'h5, 32'h7F800000},
    {32'h00800000, 32'h3F000000, 4'h3, 32'h00000000},
    {32'h7F800001, 32'h3F800000, 4'h8, 32'h7FC00000}
  };
  task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask
  // exact product of the full significands, rounded by remainder comparison; returns {flags, result}
  function automatic logic [67:0] ref_mul(input int n, input logic [63:0] a, input logic [63:0] b);
    int ew, mw, bs, emax, ea, eb, e, sh;
    logic [63:0] fa, fb, zero, inf, qn, one;
    logic [127:0] p, q, rem, half;
    logic s, ia, ib, za, zb, nan, snan, inexact;
    ew = n == 64 ? 11 : 8;
    mw = n == 64 ? 52 : 23;
    bs = (1 << (ew - 1)) - 1;
    emax = (1 << ew) - 1;
    one = 64'd1 << mw;
    ea = int'((a >> mw) & 64'(emax));
    eb = int'((b >> mw) & 64'(emax));
    fa = a & (one - 64'd1);
    fb = b & (one - 64'd1);
    s = a[n-1] ^ b[n-1];
    zero = 64'(s) << (n - 1);
    inf = zero | (64'(emax) << mw);
    qn = (64'(emax) << mw) | (one >> 1);
    nan = (ea == emax && fa != 0) || (eb == emax && fb != 0);
    snan = (ea == emax && fa != 0 && !fa[mw-1]) || (eb == emax && fb != 0 && !fb[mw-1]);
    ia = ea == emax && fa == 0;
    ib = eb == emax && fb == 0;
    za = ea == 0;
    zb = eb == 0;
    if (nan) return {snan, 3'b000, qn};
    if ((ia && zb) || (ib && za)) return {4'b1000, qn};
    if (ia || ib) return {4'b0000, inf};
    if (za || zb) return {4'b0000, zero};
    p = 128'(fa | one) * 128'(fb | one);
    e = ea + eb - bs;
    sh = mw;
    if (p >= (128'd1 << (2 * mw + 1))) begin
      sh = mw + 1;
      e++;
    end
    if (e < 1) return {4'b0011, zero};
    q = p >> sh;
    rem = p - (q << sh);
    half = 128'd1 << (sh - 1);
    inexact = rem != 0;
    if (rem > half || (rem == half && q[0])) q++;
    if (q >= (128'(one) << 1)) begin
      q = q >> 1;
      e++;
    end
    if (e >= emax) return {4'b0101, inf};
    return {3'b000, inexact, zero | (64'(e) << mw) | (q[63:0] & (one - 64'd1))};
  endfunction
  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 9);
    if (k == 0) v[30:23] = 8'h00;
    else if (k == 1) v[30:23] = 8'hFF;
    else if (k == 2) begin
      v[30:23] = 8'hFF;
      v[22] = 1'b0;
    end else if (k < 9) begin
      v[30:23] = 8'(100 + $urandom_range(0, 54));
      if (k == 3) v[22:0] = '1;
    end
    return v;
  endfunction
  // scoreboard: expected results queued at input transfer, compared in order at output transfer
  always @(negedge clk) begin
    if (!rst) exp_q.delete();
    else begin
      if (i32.out_valid && i32.out_ready) begin
        n_out++;
        if (exp_q.size() == 0) chk("sb_unexpected", 68'(exp_q.size()), 68'd1);
        else begin
          logic [67:0] e;
          e = exp_q.pop_front();
          chk("sb_result", 68'({i32.flags, i32.out}), 68'({e[67:64], e[31:0]}));
        end
      end
      if (i32.in_valid && i32.in_ready) exp_q.push_back(ref_mul(32, 64'(i32.a), 64'(i32.b)));
    end
  end
  task automatic send(input logic [31:0] x, input logic [31:0] y);
    int k;
    k = 0;
    i32.a = x;
    i32.b = y;
    i32.in_valid = 1'b1;
    @(negedge clk);
    while (!i32.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k == 100) chk("send_timeout", 68'(k), 68'd0);
    @(posedge clk);
    #1;
    i32.in_valid = 1'b0;
  endtask
  task automatic wait_out(input bit wide, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(wide ? i64.out_valid : i32.out_valid) && k < 20);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k, n0;
    logic [99:0] t;
    logic [31:0] held;
    n_chk = 0;
    n_pass = 0;
    n_out = 0;
    rst = 1'b0;
    i32.in_valid = 1'b0;
    i32.a = '0;
    i32.b = '0;
    i32.out_ready = 1'b1;
    i64.in_valid = 1'b0;
    i64.a = '0;
    i64.b = '0;
    i64.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 68'(i32.out_valid), 68'd0);
    chk("rst_out", 68'({i32.flags, i32.out}), 68'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 68'(i32.in_ready), 68'd1);
    for (int i = 0; i < 10; i++) begin
      t = DIR[i];
      send(t[99:68], t[67:36]);
      wait_out(1'b0, k);
      chk($sformatf("dir%0d_latency", i), 68'(k), 68'd3);
      chk($sformatf("dir%0d_result", i), 68'({i32.flags, i32.out}), 68'(t[35:0]));
      @(posedge clk);
      #1;
    end
    n0 = n_out;
    fork
      for (int i = 0; i < 6; i++) send(32'h3F800000 + 32'(i * 32'h00100001), 32'h40400000 + 32'(i));
      begin
        repeat (4) @(posedge clk);
        #1 i32.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (i == 0) held = i32.out;
          chk("stall_valid", 68'(i32.out_valid), 68'd1);
          chk("stall_in_ready", 68'(i32.in_ready), 68'd0);
          chk("stall_hold", 68'(i32.out), 68'(held));
        end
        @(posedge clk);
        #1 i32.out_ready = 1'b1;
      end
    join
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("stall_drain", 68'(exp_q.size()), 68'd0);
    chk("stall_count", 68'(n_out - n0), 68'd6);
    @(posedge clk);
    #1;
    n0 = n_out;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) send(rnd_op(), rnd_op());
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 i32.out_ready = $urandom_range(0, 3) != 0;
        end
        i32.out_ready = 1'b1;
      end
    join
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rnd_drain", 68'(exp_q.size()), 68'd0);
    chk("rnd_count", 68'(n_out - n0), 68'd300);
    @(posedge clk);
    #1;
    i32.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rnd_op(), rnd_op());
    chk("pre_rst_valid", 68'(i32.out_valid), 68'd1);
    #1 rst = 1'b0;
    #1 chk("rst_async_valid", 68'(i32.out_valid), 68'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    i32.out_ready = 1'b1;
    n0 = n_out;
    @(posedge clk);
    #1 chk("rst_release_ready", 68'(i32.in_ready), 68'd1);
    repeat (8) @(negedge clk);
    chk("no_stale", 68'(n_out - n0), 68'd0);
    for (int i = 0; i < 21; i++) begin
      logic [63:0] x, y;
      x = i == 0 ? 64'h3FF8000000000000 : {$urandom, $urandom};
      y = i == 0 ? 64'h4000000000000000 : {$urandom, $urandom};
      if (i > 0) begin
        x[62:52] = 11'(993 + $urandom_range(0, 60));
        y[62:52] = 11'(993 + $urandom_range(0, 60));
      end
      @(posedge clk);
      #1;
      i64.a = x;
      i64.b = y;
      i64.in_valid = 1'b1;
      @(posedge clk);
      #1 i64.in_valid = 1'b0;
      wait_out(1'b1, k);
      chk("d64_latency", 68'(k), 68'd3);
      chk("d64_model", {i64.flags, i64.out}, ref_mul(64, x, y));
      if (i == 0) chk("d64_result", {i64.flags, i64.out}, {4'h0, 64'h4008000000000000});
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
